fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Purpose : instruction fetch front end; issues sequential fetches, buffers returned words, decodes the head.
// Latency : response accepted at edge N is presented on out_* in the cycle after edge N.
// Backpressure: out_ready=0 holds the head; fetches stall once buffered + outstanding reach DEPTH.
//
// Ports:
//   clk, rstb                        clock, async active-low reset
//   req_valid/req_ready/req_addr     fetch request channel to instruction memory
//   rsp_valid/rsp_data               in-order responses, one per accepted request
//   redirect/redirect_addr           taken jump/branch; flushes buffer and restarts fetch
//   out_valid/out_ready              decoded instruction handshake to execute
//   out_pc/out_instr/out_op/out_illegal  head instruction, its PC and one-hot class
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstb,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic [8:0]        out_op,
    output logic              out_illegal
);

    localparam int                AW        = $clog2(DEPTH);
    localparam int                CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]       DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW:0]       occ;
    logic              req_fire;
    logic              rsp_keep;
    logic              push;
    logic              pop;

    // Buffered plus outstanding never exceeds DEPTH, so a push always has room.
    assign occ       = {1'b0, count} + {1'b0, inflight};
    assign req_valid = rstb & (occ < DEPTH_OCC) & ~redirect;
    assign req_addr  = fetch_pc;
    assign out_valid = (count != '0) & ~redirect;

    assign req_fire  = req_valid & req_ready;
    // Responses owed to fetches issued before a redirect are consumed by drop first.
    assign rsp_keep  = rsp_valid & (drop == '0);
    assign push      = rsp_keep & ~redirect;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            // Everything still outstanding becomes stale; the response arriving
            // this cycle (if any) is already accounted for.
            fetch_pc <= redirect_addr;
            rsp_pc   <= redirect_addr;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= drop + inflight - CW'(rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rsp_pc <= rsp_pc + PC_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (rsp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(req_fire) - CW'(rsp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: rsp_pc, instr: rsp_data};
        end
    end

    assign head      = mem[rd_ptr];
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_comb begin
        out_op = '0;
        case (head.instr[6:2])
            5'b01101: out_op[0] = 1'b1; // LUI
            5'b00101: out_op[1] = 1'b1; // AUIPC
            5'b11011: out_op[2] = 1'b1; // JAL
            5'b11001: out_op[3] = 1'b1; // JALR
            5'b11000: out_op[4] = 1'b1; // BRANCH
            5'b00000: out_op[5] = 1'b1; // LOAD
            5'b01000: out_op[6] = 1'b1; // STORE
            5'b00100: out_op[7] = 1'b1; // IMM
            5'b01100: out_op[8] = 1'b1; // REG
            default:  out_op    = '0;
        endcase
    end

    assign out_illegal = (head.instr[1:0] != 2'b11) | (out_op == '0);

endmodule
